// File: rtl/relu_serializer_if.sv
// relu_serializer_if: parallel-vector-in / serial-word-out bus for relu_serializer.
// Optional argmax outputs exist only when ARGMAX_EN is defined.
interface relu_serializer_if #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_NODES  = 500
);
`ifdef ARGMAX_EN
    localparam int unsigned IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
`endif

    logic                  i_valid;
    logic [DATA_WIDTH-1:0] din [NUM_NODES];
    logic                  o_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  o_last;
    logic                  o_overrun;
`ifdef ARGMAX_EN
    logic [IDX_W-1:0]      o_argmax;
    logic                  o_argmax_valid;
`endif

`ifdef ARGMAX_EN
    modport master (
        output i_valid, din,
        input  o_ready, o_valid, dout, o_last, o_overrun, o_argmax, o_argmax_valid
    );
    modport slave (
        input  i_valid, din,
        output o_ready, o_valid, dout, o_last, o_overrun, o_argmax, o_argmax_valid
    );
`else
    modport master (
        output i_valid, din,
        input  o_ready, o_valid, dout, o_last, o_overrun
    );
    modport slave (
        input  i_valid, din,
        output o_ready, o_valid, dout, o_last, o_overrun
    );
`endif
endinterface

// File: rtl/relu_serializer.sv
// relu_serializer: captures a parallel layer result, applies ReLU and streams it one
// word per cycle into the next layer. No backpressure; a vector arriving while a
// stream is in progress is dropped and flagged on the sticky o_overrun.
// Optional feature macro: ARGMAX_EN (running signed argmax over the raw words).
module relu_serializer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_NODES  = 500
) (
    input  logic            clk,
    input  logic            rst,
    relu_serializer_if.slave bus
);
    localparam int unsigned     IDX_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_q, state_d;

    logic                  ready_c;
    logic                  accept_c;
    logic                  step_c;
    logic                  done_c;
    logic [DATA_WIDTH-1:0] cur_word_c;

    logic [DATA_WIDTH-1:0] vec_q [NUM_NODES];
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  overrun_q, overrun_d;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? '0 : x;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: leave STREAM after the last word unless a new vector is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = STREAM;
            STREAM:  if (last_q && !accept_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready in IDLE or while the last word is on dout
    always_comb begin
        ready_c  = (state_q == IDLE) || last_q;
        accept_c = bus.i_valid && ready_c;
        step_c   = (state_q == STREAM) && !last_q;
        done_c   = (state_q == STREAM) && last_q;
    end

    assign cur_word_c = vec_q[idx_q];

    // Raw vector buffer; contents are irrelevant outside a stream so no reset
    always_ff @(posedge clk) begin
        if (accept_c) vec_q <= bus.din;
    end

    // Streaming datapath next values; idx saturates at the last index
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        last_d    = last_q;
        idx_d     = idx_q;
        overrun_d = overrun_q | (bus.i_valid & ~ready_c);
        if (accept_c) begin
            dout_d  = relu(bus.din[0]);
            valid_d = 1'b1;
            last_d  = (NUM_NODES == 1);
            idx_d   = IDX_W'(1);
        end else if (step_c) begin
            dout_d = relu(cur_word_c);
            last_d = (idx_q == LAST_IDX);
            if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
        end else if (done_c) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Streaming datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.o_ready   = ready_c;
    assign bus.o_valid   = valid_q;
    assign bus.dout      = dout_q;
    assign bus.o_last    = last_q;
    assign bus.o_overrun = overrun_q;

`ifdef ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [IDX_W-1:0]      amax_q, amax_d;
    logic [IDX_W-1:0]      argmax_q, argmax_d;
    logic                  argmax_valid_q, argmax_valid_d;

    // Running max (strict >, lowest index wins ties); published after the last word
    always_comb begin
        max_d          = max_q;
        amax_d         = amax_q;
        argmax_valid_d = done_c;
        argmax_d       = done_c ? amax_q : argmax_q;
        if (accept_c) begin
            max_d  = bus.din[0];
            amax_d = '0;
        end else if (step_c && ($signed(cur_word_c) > $signed(max_q))) begin
            max_d  = cur_word_c;
            amax_d = idx_q;
        end
    end

    // Argmax registers
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q          <= '0;
            amax_q         <= '0;
            argmax_q       <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            max_q          <= max_d;
            amax_q         <= amax_d;
            argmax_q       <= argmax_d;
            argmax_valid_q <= argmax_valid_d;
        end
    end

    assign bus.o_argmax       = argmax_q;
    assign bus.o_argmax_valid = argmax_valid_q;
`endif
endmodule

// File: tb/tb_relu_serializer.sv
// tb_relu_serializer: directed stimulus with a scoreboard of expected stream words.
module tb_relu_serializer;
    localparam int unsigned DW = 8;
    localparam int unsigned NN = 4;

    typedef struct {
        logic [DW-1:0] w;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;

    relu_serializer_if #(.DATA_WIDTH(DW), .NUM_NODES(NN)) bus ();
    relu_serializer_if #(.DATA_WIDTH(DW), .NUM_NODES(1))  bus1 ();

    relu_serializer #(.DATA_WIDTH(DW), .NUM_NODES(NN)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    relu_serializer #(.DATA_WIDTH(DW), .NUM_NODES(1))  u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t q[$];
    int   amax_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    logic ov_exp  = 1'b0;
    logic amax_pend = 1'b0;
    int   amax_pend_val = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] x);
        return ($signed(x) < 0) ? '0 : x;
    endfunction

    // Drive one vector; the model accepts it only if no words remain outstanding
    task automatic send(input int v0, input int v1, input int v2, input int v3);
        logic [DW-1:0] v [NN];
        int best;
        v[0] = DW'(v0); v[1] = DW'(v1); v[2] = DW'(v2); v[3] = DW'(v3);
        for (int i = 0; i < NN; i++) bus.din[i] = v[i];
        bus.i_valid = 1'b1;
        if (q.size() == 0) begin
            best = 0;
            for (int i = 0; i < NN; i++) begin
                q.push_back('{w: relu_m(v[i]), last: (i == NN - 1)});
                if ($signed(v[i]) > $signed(v[best])) best = i;
            end
            amax_q.push_back(best);
        end else begin
            ov_exp = 1'b1;
        end
    endtask

    // Compare the NN-node DUT against the scoreboard for the current cycle
    task automatic check();
        exp_t e;
        logic popped_last;
        popped_last = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_valid", 32'(bus.o_valid), 32'd1);
            chk("dout", 32'(bus.dout), 32'(e.w));
            chk("o_last", 32'(bus.o_last), 32'(e.last));
            popped_last = e.last;
        end else begin
            chk("o_valid_idle", 32'(bus.o_valid), 32'd0);
            chk("o_last_idle", 32'(bus.o_last), 32'd0);
        end
        chk("o_ready", 32'(bus.o_ready), 32'(q.size() == 0));
        chk("o_overrun", 32'(bus.o_overrun), 32'(ov_exp));
`ifdef ARGMAX_EN
        chk("argmax_valid", 32'(bus.o_argmax_valid), 32'(amax_pend));
        if (amax_pend) chk("argmax", 32'(bus.o_argmax), 32'(amax_pend_val));
`endif
        amax_pend = 1'b0;
        if (popped_last && amax_q.size() > 0) begin
            amax_pend     = 1'b1;
            amax_pend_val = amax_q.pop_front();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check();
        bus.i_valid  = 1'b0;
        bus1.i_valid = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_valid  = 1'b0;
        bus1.i_valid = 1'b0;
        q.delete();
        amax_q.delete();
        ov_exp    = 1'b0;
        amax_pend = 1'b0;
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_o_last", 32'(bus.o_last), 32'd0);
        chk("rst_o_overrun", 32'(bus.o_overrun), 32'd0);
        chk("rst_o_ready", 32'(bus.o_ready), 32'd1);
`ifdef ARGMAX_EN
        chk("rst_argmax", 32'(bus.o_argmax), 32'd0);
        chk("rst_argmax_valid", 32'(bus.o_argmax_valid), 32'd0);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus1.i_valid = 1'b0;
        for (int i = 0; i < NN; i++) bus.din[i] = '0;
        bus1.din[0]  = '0;
        @(posedge clk);
        do_reset();
        chk("rst1_o_valid", 32'(bus1.o_valid), 32'd0);

        // Single vector, then idle
        send(5, -3, 0, 127);
        steps(6);

        // Back-to-back: second vector accepted in the o_last cycle
        send(5, -3, 0, 127);
        steps(4);
        send(1, 2, 3, 4);
        steps(6);

        // Overrun: second vector two cycles after the first accept is dropped
        send(5, -3, 0, 127);
        steps(2);
        send(9, 9, 9, 9);
        steps(4);
        steps(2);

        // Reset mid-stream after word 1, then a normal stream with boundary values
        send(5, -3, 0, 127);
        steps(2);
        do_reset();
        steps(2);
        send(-128, -1, 0, 127);
        steps(6);

        // Argmax vectors (ties resolved to lowest index)
        send(-5, -2, -2, -9);
        steps(6);
        send(3, 9, 9, 1);
        steps(6);

        // Single-node instance: valid and last together, then idle
        bus1.din[0]  = DW'(-7);
        bus1.i_valid = 1'b1;
        step();
        chk("n1_o_valid", 32'(bus1.o_valid), 32'd1);
        chk("n1_o_last", 32'(bus1.o_last), 32'd1);
        chk("n1_dout", 32'(bus1.dout), 32'd0);
        chk("n1_o_ready", 32'(bus1.o_ready), 32'd1);
        step();
        chk("n1_o_valid_end", 32'(bus1.o_valid), 32'd0);
        chk("n1_o_last_end", 32'(bus1.o_last), 32'd0);
`ifdef ARGMAX_EN
        chk("n1_argmax_valid", 32'(bus1.o_argmax_valid), 32'd1);
        chk("n1_argmax", 32'(bus1.o_argmax), 32'd0);
`endif
        step();
        chk("n1_o_overrun", 32'(bus1.o_overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
